axis_fifo_arbiter: RTL and testbench



---
 rtl/axis_fifo_arbiter_if.sv | 26 ++
 rtl/axis_fifo_arbiter.sv | 129 ++++++++++++
 tb/tb_axis_fifo_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_fifo_arbiter_if.sv
// AXI-Stream bundle between N sources, the packet arbiter and the FIFO write port.
// master: the arbiter's view. It consumes the source beats and drives the FIFO side.
// slave : the surrounding view. The sources and FIFO drive s_* and m_tready.
interface axis_fifo_arbiter_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 16
);
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tready;

    modport master (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast
    );

    modport slave (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/axis_fifo_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream FIFO write port among N sources.
// A granted source is passed through combinationally until its tlast. Packets longer than
// MAX_BEATS are cut with a forced tlast, and the sticky trunc_err flag is set.
// Optional feature: define AXIS_ARB_PKTCNT_EN to add the per-source completed-packet
// counters on output pkt_cnt.
module axis_fifo_arbiter #(
    parameter int unsigned DW        = 16,
    parameter int unsigned N         = 4,
    parameter int unsigned MAX_BEATS = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    axis_fifo_arbiter_if.master    bus,
    output logic [$clog2(N)-1:0]   grant_idx,
    output logic                   busy,
    output logic                   trunc_err
`ifdef AXIS_ARB_PKTCNT_EN
    ,
    output logic [N*16-1:0]        pkt_cnt
`endif
);
    localparam int unsigned GIW = $clog2(N);
    localparam int unsigned CW  = $clog2(MAX_BEATS) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [CW-1:0]   beat_cnt;

    logic            found_c;
    logic [GIW-1:0]  next_g_c;
    int unsigned     idx;

    logic [DW-1:0]   m_tdata_c;
    logic            m_tvalid_c;
    logic            m_tlast_c;
    logic            force_last_c;
    logic            hs_c;
    logic [N-1:0]    s_tready_c;

    // Round-robin search: first requesting source after the last grant, with wrap.
    always_comb begin
        found_c  = 1'b0;
        next_g_c = grant_idx;
        idx      = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = 32'(grant_idx) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found_c && bus.s_tvalid[GIW'(idx)]) begin
                found_c  = 1'b1;
                next_g_c = GIW'(idx);
            end
        end
    end

    // Pass-through from the granted source; the forced tlast caps the packet length.
    always_comb begin
        m_tdata_c    = '0;
        m_tvalid_c   = 1'b0;
        m_tlast_c    = 1'b0;
        s_tready_c   = '0;
        force_last_c = (beat_cnt == CW'(MAX_BEATS - 1));
        if (state == GRANT) begin
            m_tdata_c             = bus.s_tdata[32'(grant_idx)*DW +: DW];
            m_tvalid_c            = bus.s_tvalid[grant_idx];
            m_tlast_c             = bus.s_tlast[grant_idx] | force_last_c;
            s_tready_c[grant_idx] = bus.m_tready;
        end
    end

    assign hs_c         = m_tvalid_c & bus.m_tready;
    assign bus.m_tdata  = m_tdata_c;
    assign bus.m_tvalid = m_tvalid_c;
    assign bus.m_tlast  = m_tlast_c;
    assign bus.s_tready = s_tready_c;

    // Grant FSM, beat counter and sticky truncation flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_idx <= GIW'(N - 1);
            busy      <= 1'b0;
            beat_cnt  <= '0;
            trunc_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found_c) begin
                        grant_idx <= next_g_c;
                        busy      <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (hs_c) begin
                        if (m_tlast_c) begin
                            beat_cnt <= '0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                            if (force_last_c && !bus.s_tlast[grant_idx]) begin
                                trunc_err <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXIS_ARB_PKTCNT_EN
    // Saturating count of completed (including truncated) packets per source.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else if (hs_c && m_tlast_c &&
                     pkt_cnt[32'(grant_idx)*16 +: 16] != 16'hFFFF) begin
            pkt_cnt[32'(grant_idx)*16 +: 16] <= pkt_cnt[32'(grant_idx)*16 +: 16] + 16'd1;
        end
    end
`else
    // Packet counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_axis_fifo_arbiter.sv
// Self-checking bench for axis_fifo_arbiter: directed scenarios plus a randomized phase,
// checked against a transaction-level reference model and per-source stream scoreboards.
module tb_axis_fifo_arbiter;
    localparam int unsigned N    = 4;
    localparam int unsigned DW   = 16;
    localparam int unsigned MAXB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axis_fifo_arbiter_if #(.N(N), .DW(DW)) bus ();
    logic [1:0] grant_idx;
    logic       busy;
    logic       trunc_err;
`ifdef AXIS_ARB_PKTCNT_EN
    logic [N*16-1:0] pkt_cnt;
`endif

    axis_fifo_arbiter #(.DW(DW), .N(N), .MAX_BEATS(MAXB)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .grant_idx (grant_idx),
        .busy      (busy),
        .trunc_err (trunc_err)
`ifdef AXIS_ARB_PKTCNT_EN
        ,
        .pkt_cnt   (pkt_cnt)
`endif
    );

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } beat_t;

    beat_t       srcq [N][$];
    logic [15:0] sent [N][$];
    logic [15:0] recv [N][$];
    int          order_q [$];

    int checks = 0;
    int errors = 0;
    int gap_pct = 0;
    int rdy_mode = 0;
    int cyc = 0;

    logic [N-1:0] v;
    logic [N-1:0] dl;
    logic [15:0]  dd [N];

    // Reference model state: grant owner, beats sent in the current packet, flags, counts.
    bit mb;
    int mg;
    int mc;
    bit mt;
    int mp [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mb = 1'b0;
        mg = N - 1;
        mc = 0;
        mt = 1'b0;
        for (int i = 0; i < N; i++) mp[i] = 0;
    endtask

    function automatic int rr(input int g, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            if (req[(g + k) % N]) return (g + k) % N;
        end
        return g;
    endfunction

    task automatic push_pkt(input int s, input int len, input int first, input int dir);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.d = 16'(first + dir * j);
            b.l = (j == len - 1);
            srcq[s].push_back(b);
            sent[s].push_back(b.d);
        end
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            sent[i].delete();
            recv[i].delete();
        end
        order_q.delete();
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                dd[i] = srcq[i][0].d;
                dl[i] = srcq[i][0].l;
                v[i]  = ($urandom_range(99) >= gap_pct);
            end else begin
                dd[i] = '0;
                dl[i] = 1'b0;
                v[i]  = 1'b0;
            end
            bus.s_tdata[i*DW +: DW] = dd[i];
        end
        bus.s_tvalid = v;
        bus.s_tlast  = dl;
        case (rdy_mode)
            1:       bus.m_tready = ~cyc[0];
            2:       bus.m_tready = ($urandom_range(99) < 70);
            default: bus.m_tready = 1'b1;
        endcase
    endtask

    // One clock: compare DUT against the model at negedge, advance the model, re-drive.
    task automatic cycle();
        logic [N-1:0] er;
        bit hs;
        bit lst;
        @(negedge clk);
        er = '0;
        if (mb && bus.m_tready) er[mg] = 1'b1;
        check("busy", 32'(busy), 32'(mb));
        check("grant_idx", 32'(grant_idx), 32'(mg));
        check("trunc_err", 32'(trunc_err), 32'(mt));
        check("m_tvalid", 32'(bus.m_tvalid), 32'(mb && v[mg]));
        check("m_tlast", 32'(bus.m_tlast), 32'(mb && (dl[mg] || mc == MAXB - 1)));
        check("m_tdata", 32'(bus.m_tdata), mb ? 32'(dd[mg]) : 32'd0);
        check("s_tready", 32'(bus.s_tready), 32'(er));
`ifdef AXIS_ARB_PKTCNT_EN
        for (int i = 0; i < N; i++) check("pkt_cnt", 32'(pkt_cnt[i*16 +: 16]), 32'(mp[i]));
`endif
        if (bus.m_tvalid && bus.m_tready) begin
            recv[grant_idx].push_back(bus.m_tdata);
            if (bus.m_tlast) order_q.push_back(int'(grant_idx));
        end
        hs  = mb && v[mg] && bus.m_tready;
        lst = dl[mg] || (mc == MAXB - 1);
        if (rst) begin
            model_reset();
        end else if (!mb) begin
            if (v != '0) begin
                mg = rr(mg, v);
                mb = 1'b1;
            end
        end else if (hs) begin
            void'(srcq[mg].pop_front());
            if (lst) begin
                if (!dl[mg]) mt = 1'b1;
                mc = 0;
                mb = 1'b0;
                if (mp[mg] < 65535) mp[mg]++;
            end else begin
                mc++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (srcq[i].size() > 0) return 1'b1;
        return mb;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        while (pending() && n < budget) begin
            cycle();
            n++;
        end
        if (pending()) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout observed=%0d cycles expected=done", n);
        end
        cycle();
    endtask

    task automatic check_streams();
        for (int s = 0; s < N; s++) begin
            check("stream_len", 32'(recv[s].size()), 32'(sent[s].size()));
            for (int j = 0; j < sent[s].size() && j < recv[s].size(); j++)
                check("stream_data", 32'(recv[s][j]), 32'(sent[s][j]));
        end
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        cycle();
        flush();
        rst = 1'b0;
        drive();
    endtask

    initial begin
        int n1;
        int guard;
        rst = 1'b1;
        v = '0;
        dl = '0;
        for (int i = 0; i < N; i++) dd[i] = '0;
        model_reset();
        drive();
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        drive();

        // Single source, three beats 3,2,1.
        push_pkt(0, 3, 3, -1);
        drive();
        drain(50);
        check_streams();

        // Round robin across sources 0..2, two packets each, always valid.
        hard_reset();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < 3; s++) push_pkt(s, 2, 16'h100 * (s + 1) + 16'h10 * r, 1);
        drive();
        drain(100);
        check_streams();
        check("rr_count", 32'(order_q.size()), 32'd6);
        for (int j = 0; j < 6 && j < order_q.size(); j++)
            check("rr_order", 32'(order_q[j]), 32'(j % 3));
`ifdef AXIS_ARB_PKTCNT_EN
        check("pkt_cnt_rr0", 32'(pkt_cnt[15:0]),  32'd2);
        check("pkt_cnt_rr1", 32'(pkt_cnt[31:16]), 32'd2);
        check("pkt_cnt_rr2", 32'(pkt_cnt[47:32]), 32'd2);
        check("pkt_cnt_rr3", 32'(pkt_cnt[63:48]), 32'd0);
`endif
        flush();

        // Backpressure: m_tready alternating during a 4-beat packet.
        rdy_mode = 1;
        push_pkt(2, 4, 16'hA0, 1);
        drive();
        drain(100);
        check_streams();
        rdy_mode = 0;
        flush();

        // Truncation: 6 beats against a 4-beat limit become two packets.
        push_pkt(1, 6, 16'h50, 1);
        drive();
        drain(100);
        check_streams();
        check("trunc_flag", 32'(trunc_err), 32'd1);
        check("trunc_pkts", 32'(order_q.size()), 32'd2);
        flush();

        // Reset after beat 2 of a 5-beat packet from source 3.
        push_pkt(3, 5, 16'h300, 1);
        drive();
        guard = 0;
        while (recv[3].size() < 2 && guard < 20) begin
            cycle();
            guard++;
        end
        check("rst_mid_beats", 32'(recv[3].size()), 32'd2);
        rst = 1'b1;
        cycle();
        flush();
        rst = 1'b0;
        push_pkt(0, 2, 16'h10, 1);
        push_pkt(3, 2, 16'h30, 1);
        drive();
        drain(100);
        check_streams();
        n1 = order_q.size();
        check("rst_first_cnt", 32'(n1), 32'd2);
        if (n1 > 0) check("rst_first_win", 32'(order_q[0]), 32'd0);
        flush();

        // Randomized traffic with source gaps and random backpressure.
        gap_pct = 25;
        rdy_mode = 2;
        for (int p = 0; p < 40; p++)
            push_pkt($urandom_range(N - 1), $urandom_range(7, 1), $urandom_range(16'hFFFF), 1);
        drive();
        drain(3000);
        check_streams();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
